// File: rtl/ysyx_040750_clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled mtime, per-hart mtimecmp
// and msip, AXI-lite style read/write channels with OKAY/SLVERR responses.
module ysyx_040750_clint_mh #(
    parameter int unsigned NHART     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    output logic [NHART-1:0] O_mtip,
    output logic [NHART-1:0] O_msip,
    input  logic [31:0]      I_clint_araddr,
    input  logic             I_clint_arvalid,
    output logic             O_clint_arready,
    output logic [63:0]      O_clint_rdata,
    output logic [1:0]       O_clint_rresp,
    output logic             O_clint_rvalid,
    input  logic             I_clint_rready,
    input  logic [31:0]      I_clint_awaddr,
    input  logic             I_clint_awvalid,
    output logic             O_clint_awready,
    input  logic [63:0]      I_clint_wdata,
    input  logic [7:0]       I_clint_wstrb,
    input  logic             I_clint_wvalid,
    output logic             O_clint_wready,
    output logic [1:0]       O_clint_bresp,
    output logic             O_clint_bvalid,
    input  logic             I_clint_bready
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = (NHART > 1) ? $clog2(NHART) : 1;
    localparam logic [28:0] BASE_WORD  = BASE_ADDR[31:3];
    localparam logic [28:0] MTIME_WORD = 29'h17FF;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {K_NONE, K_MSIP, K_CMP, K_TIME} kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [10:0] idx;
    } dec_t;

    logic [63:0]      mtime;
    logic [PW-1:0]    presc;
    logic [NHART-1:0] msip;
    logic [63:0]      mtimecmp [NHART];

    logic             aw_held;
    logic [28:0]      aw_word;
    logic             w_held;
    logic [63:0]      w_data;
    logic [7:0]       w_strb;
    logic             bvalid;
    logic [1:0]       bresp;
    logic             rvalid;
    logic [63:0]      rdata;
    logic [1:0]       rresp;

    logic             tick;
    logic             commit;
    dec_t             rdec;
    dec_t             wdec;
    logic [63:0]      rd_val;
    logic [63:0]      wr_new;
    logic [NHART-1:0] mtip;
    logic             unused_addr_bits;

    // Word-granular decode relative to the base; wraps below base land unmapped.
    function automatic dec_t decode(input logic [28:0] waddr);
        logic [28:0] word;
        dec_t        d;
        word   = waddr - BASE_WORD;
        d.kind = K_NONE;
        d.idx  = word[10:0];
        if (word == MTIME_WORD) begin
            d.kind = K_TIME;
        end else if (word[28:11] == 18'd1 && 32'(word[10:0]) < NHART) begin
            d.kind = K_CMP;
        end else if (word[28:11] == 18'd0 && {20'd0, word[10:0], 1'b0} < NHART) begin
            d.kind = K_MSIP;
        end
        return d;
    endfunction

    // Current 64-bit view of a decoded register; unmapped reads as zero.
    function automatic logic [63:0] read_reg(input dec_t d);
        logic [63:0] v;
        v = '0;
        case (d.kind)
            K_TIME: v = mtime;
            K_CMP: begin
                for (int unsigned h = 0; h < NHART; h++) begin
                    if (11'(h) == d.idx) v = mtimecmp[IW'(h)];
                end
            end
            K_MSIP: begin
                for (int unsigned h = 0; h < NHART; h++) begin
                    if (11'(h / 2) == d.idx) begin
                        if (h % 2 == 1) v[32] = msip[IW'(h)];
                        else            v[0]  = msip[IW'(h)];
                    end
                end
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Byte-lane merge of write data over the old register value.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] m;
        m = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) m[6'(b * 8) +: 8] = data[6'(b * 8) +: 8];
        end
        return m;
    endfunction

    // Decode, commit qualification and tick generation.
    always_comb begin
        tick   = (presc == PW'(TICK_DIV - 1));
        commit = aw_held && w_held && !bvalid;
        rdec   = decode(I_clint_araddr[31:3]);
        wdec   = decode(aw_word);
        rd_val = read_reg(rdec);
        wr_new = merge(read_reg(wdec), w_data, w_strb);
    end

    // Per-hart timer compare against the shared mtime.
    always_comb begin
        mtip = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            mtip[IW'(h)] = (mtime >= mtimecmp[IW'(h)]);
        end
    end

    assign unused_addr_bits = ^{I_clint_araddr[2:0], I_clint_awaddr[2:0]};

    assign O_mtip          = mtip;
    assign O_msip          = msip;
    assign O_clint_arready = !rvalid;
    assign O_clint_rdata   = rdata;
    assign O_clint_rresp   = rresp;
    assign O_clint_rvalid  = rvalid;
    assign O_clint_awready = !aw_held;
    assign O_clint_wready  = !w_held;
    assign O_clint_bresp   = bresp;
    assign O_clint_bvalid  = bvalid;

    // AW/W holders, commit and write response.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            aw_held <= 1'b0;
            aw_word <= '0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (!aw_held && I_clint_awvalid) begin
                aw_held <= 1'b1;
                aw_word <= I_clint_awaddr[31:3];
            end
            if (!w_held && I_clint_wvalid) begin
                w_held <= 1'b1;
                w_data <= I_clint_wdata;
                w_strb <= I_clint_wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= (wdec.kind == K_NONE) ? RESP_SLV : RESP_OKAY;
            end else if (bvalid && I_clint_bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle latency, response held until rready.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (rvalid) begin
            if (I_clint_rready) rvalid <= 1'b0;
        end else if (I_clint_arvalid) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= (rdec.kind == K_NONE) ? RESP_SLV : RESP_OKAY;
        end
    end

    // Prescaler and mtime; a committed mtime write overrides the tick.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (commit && wdec.kind == K_TIME) begin
                mtime <= wr_new;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // Per-hart mtimecmp and msip updates.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int unsigned h = 0; h < NHART; h++) begin
                mtimecmp[IW'(h)] <= '1;
            end
            msip <= '0;
        end else if (commit) begin
            for (int unsigned h = 0; h < NHART; h++) begin
                if (wdec.kind == K_CMP && 11'(h) == wdec.idx) begin
                    mtimecmp[IW'(h)] <= wr_new;
                end
                if (wdec.kind == K_MSIP && 11'(h / 2) == wdec.idx) begin
                    msip[IW'(h)] <= (h % 2 == 1) ? wr_new[32] : wr_new[0];
                end
            end
        end
    end

endmodule
